// File: rtl/apb_2_lint_pkg.sv
// Shared types and defaults for the APB-to-LINT bridge.
// The optional timeout is enabled by defining APB2LINT_TIMEOUT_EN.
package apb_2_lint_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } state_e;

    localparam int unsigned TIMEOUT_CYCLES_DEFAULT = 255;

    // Timeout counter is never narrower than 8 bits.
    function automatic int unsigned cnt_width(input int unsigned limit);
        return ($clog2(limit + 1) > 8) ? $clog2(limit + 1) : 8;
    endfunction

endpackage

// File: rtl/apb_2_lint.sv
// APB slave that forwards each transfer as a single LINT request/response.
// Optional timeout (PSLVERR on expiry) is enabled by defining APB2LINT_TIMEOUT_EN.
module apb_2_lint
    import apb_2_lint_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned BE_WIDTH       = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] PADDR,
    input  logic [DATA_WIDTH-1:0] PWDATA,
    input  logic                  PWRITE,
    input  logic                  PSEL,
    input  logic                  PENABLE,
    output logic [DATA_WIDTH-1:0] PRDATA,
    output logic                  PREADY,
    output logic                  PSLVERR,
    output logic                  data_req_o,
    output logic [ADDR_WIDTH-1:0] data_add_o,
    output logic                  data_wen_o,
    output logic [DATA_WIDTH-1:0] data_wdata_o,
    output logic [BE_WIDTH-1:0]   data_be_o,
    input  logic                  data_gnt_i,
    input  logic                  data_r_valid_i,
    input  logic [DATA_WIDTH-1:0] data_r_rdata_i
);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  write_q, write_d;
    logic                  abort_q, abort_d;

`ifdef APB2LINT_TIMEOUT_EN
    localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             timeout;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            write_q <= 1'b0;
            abort_q <= 1'b0;
`ifdef APB2LINT_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            write_q <= write_d;
            abort_q <= abort_d;
`ifdef APB2LINT_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        write_d = write_q;
        abort_d = abort_q;
`ifdef APB2LINT_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
        timeout = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (PSEL) begin
                    addr_d  = PADDR;
                    wdata_d = PWDATA;
                    write_d = PWRITE;
                    abort_d = 1'b0;
                    state_d = REQ;
`ifdef APB2LINT_TIMEOUT_EN
                    cnt_d   = '0;
                    err_d   = 1'b0;
`endif
                end
            end
            REQ: begin
                if (!PSEL) abort_d = 1'b1;
                if (data_gnt_i) state_d = WAIT_R;
            end
            WAIT_R: begin
                if (!PSEL) abort_d = 1'b1;
                // A master that dropped PSEL gets no response phase at all.
                if (data_r_valid_i) begin
                    rdata_d = write_q ? '0 : data_r_rdata_i;
                    state_d = (abort_q || !PSEL) ? IDLE : RESP;
                end
            end
            RESP: begin
                if (!PSEL || PENABLE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
`ifdef APB2LINT_TIMEOUT_EN
        if (state_q == REQ || state_q == WAIT_R) begin
            cnt_d   = cnt_q + 1'b1;
            timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
        end
        if (timeout) begin
            rdata_d = '0;
            err_d   = 1'b1;
            state_d = (abort_q || !PSEL) ? IDLE : RESP;
        end
`endif
    end

    assign data_req_o   = (state_q == REQ);
    assign data_add_o   = addr_q;
    assign data_wdata_o = wdata_q;
    assign data_wen_o   = ~write_q;
    assign data_be_o    = '1;
    assign PRDATA       = rdata_q;
    assign PREADY       = (state_q == RESP) && PSEL && PENABLE;
`ifdef APB2LINT_TIMEOUT_EN
    assign PSLVERR      = (state_q == RESP) && err_q;
`else
    assign PSLVERR      = 1'b0;
`endif

endmodule

// File: tb/tb_apb_2_lint.sv
// Self-checking bench for apb_2_lint: vector table plus corner-case sequences.
// Define APB2LINT_TIMEOUT_EN to also exercise the timeout path (TIMEOUT_CYCLES=16).
module tb_apb_2_lint;

`ifdef APB2LINT_TIMEOUT_EN
    localparam int TO = 16;
`else
    localparam int TO = 255;
`endif
    localparam logic [31:0] JUNK = 32'h5A5A_C3C3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] PADDR = '0, PWDATA = '0, PRDATA;
    logic        PWRITE = 1'b0, PSEL = 1'b0, PENABLE = 1'b0, PREADY, PSLVERR;
    logic        data_req_o, data_wen_o, data_gnt_i = 1'b0, data_r_valid_i = 1'b0;
    logic [31:0] data_add_o, data_wdata_o, data_r_rdata_i = '0;
    logic [3:0]  data_be_o;

    apb_2_lint #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .BE_WIDTH(4), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .data_req_o(data_req_o), .data_add_o(data_add_o), .data_wen_o(data_wen_o),
        .data_wdata_o(data_wdata_o), .data_be_o(data_be_o), .data_gnt_i(data_gnt_i),
        .data_r_valid_i(data_r_valid_i), .data_r_rdata_i(data_r_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        stray_idle;
        logic        stray_gnt;
        logic        b2b;
        logic        exp_err;
        logic [31:0] exp_prdata;
        int          exp_cycles;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                                input logic [31:0] rd, input int gd, input int rv,
                                input logic si, input logic sg, input logic b);
        vec_t v;
        v.write = wr; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.gnt_dly = gd; v.rv_dly = rv; v.stray_idle = si; v.stray_gnt = sg; v.b2b = b;
        v.exp_err = 1'b0;
        v.exp_prdata = wr ? 32'h0 : rd;
        // setup + (gd+1) REQ cycles + (rv+1) WAIT_R cycles + access cycle
        v.exp_cycles = gd + rv + 4;
        return v;
    endfunction

    task automatic idle_cycle();
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
        @(posedge clk);
    endtask

    // Plays APB master and LINT slave together, one cycle at a time.
    task automatic run_xfer(input vec_t v);
        int   req_cnt = 0;
        int   wait_cnt = 0;
        int   cyc = 1;
        bit   granted = 0;
        bit   done = 0;
        bit   gnt_now;
        logic [31:0] e;
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = v.addr; PWDATA = v.wdata; PWRITE = v.write;
        data_gnt_i = 1'b0; data_r_valid_i = v.stray_idle; data_r_rdata_i = JUNK;
        exp_q.push_back(v.exp_prdata);
        #1 check("setup_req", data_req_o, 1'b0);
        check("setup_pready", PREADY, 1'b0);
        @(posedge clk);
        while (!done && cyc < 400) begin
            @(negedge clk);
            cyc++;
            PENABLE = 1'b1; data_gnt_i = 1'b0; data_r_valid_i = 1'b0;
            if (data_req_o) begin
                req_cnt++;
                data_gnt_i = (req_cnt > v.gnt_dly);
                if (data_gnt_i && v.stray_gnt) begin
                    data_r_valid_i = 1'b1; data_r_rdata_i = JUNK;
                end
                check("req_addr", data_add_o, v.addr);
                check("req_wdata", data_wdata_o, v.wdata);
                check("req_wen", data_wen_o, !v.write);
                check("req_be", data_be_o, 4'hF);
            end else if (granted) begin
                data_r_valid_i = (wait_cnt == v.rv_dly);
                data_r_rdata_i = v.rdata;
                wait_cnt++;
            end
            #1;
            if (PREADY) begin
                done = 1;
                if (exp_q.size() == 0) check("scoreboard_empty", 32'd1, 32'd0);
                else begin
                    e = exp_q.pop_front();
                    check("prdata", PRDATA, e);
                end
                check("pslverr", PSLVERR, v.exp_err);
                check("latency", cyc, v.exp_cycles);
                if (!v.exp_err) check("req_cycles", req_cnt, v.gnt_dly + 1);
            end else if (!data_req_o) begin
                check("pslverr_idle", PSLVERR, 1'b0);
            end
            gnt_now = data_gnt_i && data_req_o;
            @(posedge clk);
            if (gnt_now) granted = 1;
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        vec_t v;
        vecs.push_back(mk(1'b0, 32'h1A10_0004, 32'h0, 32'hDEAD_BEEF, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1'b1, 32'h1A10_1000, 32'h0000_00A5, 32'h1234_5678, 5, 0, 0, 0, 0));
        vecs.push_back(mk(1'b0, 32'h1A10_0008, 32'h0, 32'hCAFE_F00D, 0, 0, 1, 1, 0));
        vecs.push_back(mk(1'b0, 32'h1A10_000C, 32'h0, 32'h1357_9BDF, 2, 3, 0, 0, 0));
        vecs.push_back(mk(1'b1, 32'h1A10_2004, 32'hFFFF_0001, 32'h7777_7777, 1, 2, 0, 1, 0));
        vecs.push_back(mk(1'b0, 32'h1A10_0010, 32'h0, 32'hAAAA_0001, 0, 0, 0, 0, 0));
        vecs.push_back(mk(1'b0, 32'h1A10_0014, 32'h0, 32'hAAAA_0002, 1, 1, 0, 0, 1));
        for (int i = 0; i < 6; i++) begin
            vecs.push_back(mk(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                              $urandom_range(0, 4), $urandom_range(0, 4),
                              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                              1'($urandom_range(0, 1))));
        end

        // Reset state
        #1;
        check("rst_req", data_req_o, 1'b0);
        check("rst_pready", PREADY, 1'b0);
        check("rst_pslverr", PSLVERR, 1'b0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_addr", data_add_o, 32'h0);
        check("rst_wdata", data_wdata_o, 32'h0);
        check("rst_wen", data_wen_o, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        foreach (vecs[i]) begin
            if (!vecs[i].b2b) idle_cycle();
            run_xfer(vecs[i]);
        end

        // Stray response while idle: no request, no response phase
        idle_cycle();
        @(negedge clk);
        data_r_valid_i = 1'b1; data_r_rdata_i = JUNK;
        #1 check("stray_idle_req", data_req_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        data_r_valid_i = 1'b0;
        #1 check("stray_idle_req2", data_req_o, 1'b0);
        check("stray_idle_pready", PREADY, 1'b0);

        // Reset while in WAIT_R, then a leftover response after release
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h1A10_0020; PWRITE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        PENABLE = 1'b1; data_gnt_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_gnt_i = 1'b0;
        rst_n = 1'b0;
        #1 check("arst_req", data_req_o, 1'b0);
        check("arst_pready", PREADY, 1'b0);
        check("arst_prdata", PRDATA, 32'h0);
        check("arst_wen", data_wen_o, 1'b1);
        check("arst_addr", data_add_o, 32'h0);
        PSEL = 1'b0; PENABLE = 1'b0;
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        data_r_valid_i = 1'b1; data_r_rdata_i = JUNK;
        @(posedge clk);
        @(negedge clk);
        data_r_valid_i = 1'b0;
        #1 check("leftover_req", data_req_o, 1'b0);
        check("leftover_pready", PREADY, 1'b0);
        run_xfer(mk(1'b0, 32'h1A10_0024, 32'h0, 32'h0123_4567, 0, 1, 0, 0, 0));

        // PSEL dropped mid-transfer: lint finishes, no PREADY
        idle_cycle();
        @(negedge clk);
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = 32'h1A10_0030; PWRITE = 1'b0;
        @(posedge clk);
        @(negedge clk);
        PSEL = 1'b0; PENABLE = 1'b0; data_gnt_i = 1'b1;
        #1 check("abort_req", data_req_o, 1'b1);
        @(posedge clk);
        @(negedge clk);
        data_gnt_i = 1'b0; data_r_valid_i = 1'b1; data_r_rdata_i = JUNK;
        #1 check("abort_req_done", data_req_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        data_r_valid_i = 1'b0;
        #1 check("abort_pready", PREADY, 1'b0);
        check("abort_req_idle", data_req_o, 1'b0);
        run_xfer(mk(1'b0, 32'h1A10_0034, 32'h0, 32'h89AB_CDEF, 0, 0, 0, 0, 0));

`ifdef APB2LINT_TIMEOUT_EN
        idle_cycle();
        v = mk(1'b0, 32'h1A10_0040, 32'h0, 32'hFEED_FACE, 100000, 0, 0, 0, 0);
        v.exp_err = 1'b1;
        v.exp_prdata = 32'h0;
        v.exp_cycles = TO + 2;
        run_xfer(v);
        idle_cycle();
        run_xfer(mk(1'b0, 32'h1A10_0044, 32'h0, 32'h2468_ACE0, 0, 0, 0, 0, 0));
`endif
        idle_cycle();
        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
